// File: rtl/spectrum_ram_writer_if.sv
// Streamed FFT magnitude beats into the spectrogram RAM writer.
// Driver owns valid/data/last; the writer owns ready.
interface spectrum_ram_writer_if #(
  parameter int IN_W = 16
);
  logic            s_valid;
  logic            s_ready;
  logic [IN_W-1:0] s_data;
  logic            s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/spectrum_ram_writer.sv
// Writes the kept half of each FFT frame into the banked spectrogram RAM
// and tracks the ring of spectra whose oldest slot feeds the display.
module spectrum_ram_writer #(
  parameter int NO_BANKS       = 2,
  parameter int RAM_ADDR_WIDTH = 12,
  parameter int NO_FFTS        = 50,
  parameter int FFT_SIZE       = 256,
  parameter int IN_W           = 16,
  parameter int PIX_W          = 4,
  parameter int SHIFT          = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spectrum_ram_writer_if.slave       s,
  input  logic                       freeze,
  output logic [NO_BANKS-1:0]        wr_bank_select,
  output logic [RAM_ADDR_WIDTH-1:0]  wr_address,
  output logic [PIX_W-1:0]           wr_data,
  output logic [$clog2(NO_FFTS)-1:0] oldest_fft_idx,
  output logic                       frame_done,
  output logic                       frame_err
);

  localparam int W    = $clog2(NO_FFTS);
  localparam int HALF = FFT_SIZE / 2;
  localparam int BW   = $clog2(HALF);
  localparam int CW   = $clog2(FFT_SIZE);
  localparam int PMAX = (2 ** PIX_W) - 1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    SKIP,
    COMMIT,
    DROP
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [CW-1:0]   bin_cnt;
  logic [W-1:0]    wr_idx;
  logic            filled;
  logic            frz;

  logic            acc;
  logic [CW-1:0]   cur_bin;
  logic            frz_now;
  logic [IN_W-1:0] sh;
  logic [PIX_W-1:0] pix;
  logic            last_bin;
  logic            wrap;
  logic [W-1:0]    idx_nxt;
  logic            filled_nxt;

  always_comb begin
    acc        = s.s_valid && s.s_ready;
    cur_bin    = (state == IDLE) ? '0 : bin_cnt;
    frz_now    = (state == IDLE) ? freeze : frz;
    sh         = s.s_data >> SHIFT;
    pix        = (sh > IN_W'(PMAX)) ? PIX_W'(PMAX)
                                    : sh[PIX_W-1:0];
    last_bin   = (cur_bin == CW'(FFT_SIZE - 1));
    wrap       = (wr_idx == W'(NO_FFTS - 1));
    idx_nxt    = wrap ? '0 : wr_idx + 1'b1;
    filled_nxt = filled | wrap;
  end

  // A frame ends at s_last or the final bin; only both together commit.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (acc) nxt = s.s_last ? DROP : WRITE;
      end
      WRITE: begin
        if (acc) begin
          if (s.s_last)
            nxt = DROP;
          else if (cur_bin == CW'(HALF - 1))
            nxt = SKIP;
        end
      end
      SKIP: begin
        if (acc) begin
          if (last_bin)
            nxt = s.s_last ? COMMIT : DROP;
          else if (s.s_last)
            nxt = DROP;
        end
      end
      COMMIT:  nxt = IDLE;
      DROP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      s.s_ready      <= 1'b0;
      bin_cnt        <= '0;
      wr_idx         <= '0;
      filled         <= 1'b0;
      frz            <= 1'b0;
      wr_bank_select <= '0;
      wr_address     <= '0;
      wr_data        <= '0;
      oldest_fft_idx <= '0;
      frame_done     <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      state          <= nxt;
      s.s_ready      <= (nxt == IDLE) || (nxt == WRITE)
                     || (nxt == SKIP);
      frame_done     <= (nxt == COMMIT);
      frame_err      <= (nxt == DROP);
      wr_bank_select <= '0;
      if (acc) begin
        bin_cnt <= cur_bin + 1'b1;
        if (state == IDLE) frz <= freeze;
        if (cur_bin < CW'(HALF) && !frz_now) begin
          wr_bank_select <= NO_BANKS'(1) << wr_idx[W-1];
          wr_address     <= {wr_idx[W-2:0], cur_bin[BW-1:0]};
          wr_data        <= pix;
        end
      end
      if (state == COMMIT || state == DROP) bin_cnt <= '0;
      if (state == COMMIT && !frz) begin
        wr_idx         <= idx_nxt;
        filled         <= filled_nxt;
        oldest_fft_idx <= filled_nxt ? idx_nxt : '0;
      end
    end
  end

endmodule

// File: tb/tb_spectrum_ram_writer.sv
// Randomised frames against a ring-of-spectra reference model.
// Expected writes/events are queued at issue and popped by a monitor.
module tb_spectrum_ram_writer;

  localparam int NO_FFTS = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze = 1'b0;
  logic [1:0]  wr_bank_select;
  logic [11:0] wr_address;
  logic [3:0]  wr_data;
  logic [5:0]  oldest_fft_idx;
  logic        frame_done;
  logic        frame_err;

  spectrum_ram_writer_if #(.IN_W(16)) sif ();

  spectrum_ram_writer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s              (sif),
    .freeze         (freeze),
    .wr_bank_select (wr_bank_select),
    .wr_address     (wr_address),
    .wr_data        (wr_data),
    .oldest_fft_idx (oldest_fft_idx),
    .frame_done     (frame_done),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  bank;
    logic [11:0] addr;
    logic [3:0]  data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_ev[$];
  int  errors = 0;
  int  checks = 0;
  int  committed = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_bank_select != 2'b00) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 32'(wr_bank_select), 0);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_bank", 32'(wr_bank_select), 32'(e.bank));
          chk("wr_addr", 32'(wr_address), 32'(e.addr));
          chk("wr_data", 32'(wr_data), 32'(e.data));
        end
      end
      if (frame_done || frame_err) begin
        int ev;
        ev = (frame_done ? 1 : 0) + (frame_err ? 2 : 0);
        if (exp_ev.size() == 0)
          chk("unexpected_event", 32'(ev), 0);
        else
          chk("frame_event", 32'(ev), 32'(exp_ev.pop_front()));
      end
    end
  end

  task automatic beat(input logic [15:0] d, input logic l,
                      output bit ok);
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_last  = l;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (sif.s_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  task automatic send_frame(input int nbeats, input bit with_last,
                            input bit frz, input bit ramp,
                            input bit abort);
    bit          ok;
    int          slot;
    bit          good;
    logic [15:0] d;
    int          q;
    wr_t         e;
    slot = committed % NO_FFTS;
    good = (nbeats == 256) && with_last;
    freeze = frz;
    for (int k = 0; k < nbeats; k++) begin
      if (ramp)
        d = 16'(k * 256);
      else if ($urandom_range(0, 1) == 1)
        d = 16'($urandom_range(0, 4095));
      else
        d = 16'($urandom);
      q = int'(d) / 256;
      if (k < 128 && !frz) begin
        e.bank = (slot < 32) ? 2'b01 : 2'b10;
        e.addr = 12'((slot % 32) * 128 + k);
        e.data = 4'((q > 15) ? 15 : q);
        exp_wr.push_back(e);
      end
      if (k == nbeats - 1 && !abort) exp_ev.push_back(good ? 1 : 2);
      if ($urandom_range(0, 7) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
      beat(d, with_last && (k == nbeats - 1), ok);
      if (!ok) begin
        chk("beat_accept_timeout", 0, 1);
        freeze = 1'b0;
        return;
      end
    end
    freeze = 1'b0;
    if (abort) return;
    if (good && !frz) committed++;
    repeat (4) @(negedge clk);
    chk("events_drained", 32'(exp_ev.size()), 0);
    chk("writes_drained", 32'(exp_wr.size()), 0);
    chk("oldest_fft_idx", 32'(oldest_fft_idx),
        (committed >= NO_FFTS) ? 32'(committed % NO_FFTS) : 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_s_ready", 32'(sif.s_ready), 0);
    chk("rst_bank", 32'(wr_bank_select), 0);
    chk("rst_addr", 32'(wr_address), 0);
    chk("rst_data", 32'(wr_data), 0);
    chk("rst_oldest", 32'(oldest_fft_idx), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_err", 32'(frame_err), 0);
  endtask

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_last  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    send_frame(256, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 2; i <= 51; i++)
      send_frame(256, 1'b1, 1'b0, 1'b0, 1'b0);

    send_frame(101, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(256, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(256, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(256, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(256, 1'b1, 1'b0, 1'b0, 1'b0);

    send_frame(256, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(256, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(60, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    chk("pre_reset_writes_drained", 32'(exp_wr.size()), 0);
    exp_wr.delete();
    exp_ev.delete();
    committed = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(256, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(256, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
